// File: rtl/mcu51_bus_pkg.sv
// Shared types and constants for the MCU memory bus controller.
// Holds the transaction FSM states, the wait-counter width and the error read value.
package mcu51_bus_pkg;

    localparam int WAIT_W = 4;
    localparam logic [7:0] ERR_READ_DATA = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        DATA,
        HOLD
    } bus_state_t;

    // Everything the controller needs from the CPU, frozen at capture time.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        write;
        logic        data_space;
        logic        psen_n;
    } bus_req_t;

    function automatic logic [WAIT_W-1:0] clamp_wait(input int unsigned cycles);
        return (cycles > 15) ? WAIT_W'(15) : WAIT_W'(cycles);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the wait phase of a bus transaction.
// Flags let the FSM leave WAIT on the cycle the count reaches zero.
module mem_wait_counter
    import mcu51_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              decrement,
    output logic              zero,
    output logic              last
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == WAIT_W'(1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side bus controller bridging one strobe-based CPU bus to a synchronous
// program ROM and data RAM, with programmable wait states and error signalling.
module mem_bus_ctrl
    import mcu51_bus_pkg::*;
#(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        read_en,
    input  logic        write_en,
    input  logic        memory_select,
    input  logic        PSEN,
    output logic        ready,
    output logic        bus_err,
    output logic        rom_en,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam logic [WAIT_W-1:0] ROM_LOAD = clamp_wait(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_LOAD = clamp_wait(RAM_WAIT);

    bus_state_t        state;
    bus_state_t        state_next;
    bus_req_t          req;
    logic [7:0]        read_buf;
    logic              ready_q;
    logic              err_q;
    logic              start;
    logic              access_err;
    logic              prog_read;
    logic [WAIT_W-1:0] load_value;
    logic              cnt_zero;
    logic              cnt_last;
    logic              drive_bus;

    // Exactly one strobe starts a transaction; both together is ignored.
    assign start      = read_en ^ write_en;
    assign access_err = !req.data_space && (req.write || req.psen_n);
    assign prog_read  = !req.data_space && !req.write && !req.psen_n;
    assign load_value = req.data_space ? RAM_LOAD : ROM_LOAD;

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (state == SETUP),
        .load_value (load_value),
        .decrement  (state == WAIT),
        .zero       (cnt_zero),
        .last       (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = (load_value != '0) ? WAIT : DATA;
            WAIT:    if (cnt_last || cnt_zero) state_next = DATA;
            DATA:    state_next = HOLD;
            HOLD:    if (!read_en && !write_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rom_en    = (state == SETUP) && prog_read;
        ram_en    = (state == SETUP) && req.data_space;
        ram_we    = (state == SETUP) && req.data_space && req.write;
        drive_bus = (state == HOLD) && read_en && !req.write;
    end

    // Capture, read buffer and the registered completion pulses; ready and
    // bus_err rise on the edge that leaves DATA so they appear in HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req      <= '0;
            read_buf <= 8'h00;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if ((state == IDLE) && start) begin
                req.addr       <= addr_bus;
                req.write      <= write_en;
                req.data_space <= memory_select;
                req.psen_n     <= PSEN;
                if (write_en) begin
                    req.wdata <= data_bus;
                end
            end
            if (state == DATA) begin
                ready_q <= 1'b1;
                err_q   <= access_err;
                if (!req.write) begin
                    if (access_err) begin
                        read_buf <= ERR_READ_DATA;
                    end else if (req.data_space) begin
                        read_buf <= ram_rdata;
                    end else begin
                        read_buf <= rom_rdata;
                    end
                end
            end
        end
    end

    assign ready     = ready_q;
    assign bus_err   = err_q;
    assign rom_addr  = req.addr;
    assign ram_addr  = req.addr[7:0];
    assign ram_wdata = req.wdata;
    assign data_bus  = drive_bus ? read_buf : 8'hzz;

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters SHALL be: ROM_WAIT, default 1, wait cycles for program fetch (0..15); RAM_WAIT, default 0, wait cycles for data access (0..15).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr_bus  input  16  CPU address.
REQ-005 data_bus  inout  8  CPU data bus; driven only as in REQ-018, else high-Z.
REQ-006 read_en / write_en  input  1 each  CPU read / write strobes, active-high, held until ready seen.
REQ-007 memory_select  input  1  1 = data RAM space, 0 = program space.
REQ-008 PSEN  input  1  program store enable, active-low; qualifies program reads.
REQ-009 ready  output  1  one-cycle pulse, transaction complete.
REQ-010 bus_err  output  1  one-cycle pulse, coincident with ready, illegal access.
REQ-011 rom_en  output  1;  rom_addr  output  16;  rom_rdata  input  8  synchronous ROM port, 1-cycle read latency.
REQ-012 ram_en, ram_we  output  1;  ram_addr  output  8;  ram_wdata  output  8;  ram_rdata  input  8  synchronous RAM port, 1-cycle read latency.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, WAIT, DATA, HOLD.
REQ-014 IDLE: when read_en xor write_en is high, capture addr_bus, memory_select, PSEN, direction, and (writes) data_bus into registers; go SETUP.
REQ-015 read_en and write_en both high in IDLE: no capture, remain IDLE, no pulses.
REQ-016 SETUP: assert rom_en (program read) or ram_en (+ram_we for data write) for exactly one cycle with captured address; load wait counter with ROM_WAIT or RAM_WAIT; go WAIT if load value >0, else DATA.
REQ-017 WAIT: decrement counter each cycle; go DATA on the cycle the counter reaches 0 (WAIT lasts exactly N cycles).
REQ-018 DATA: latch rom_rdata/ram_rdata into read buffer (reads), pulse ready; go HOLD. data_bus SHALL be driven with the read buffer from the cycle after DATA while in HOLD and read_en high.
REQ-019 HOLD: remain until read_en and write_en are both low, then IDLE; one transaction per strobe assertion.
REQ-020 Read latency: ready asserted 2+N cycles after IDLE capture edge (N = applicable wait count).
REQ-021 ram_addr SHALL be addr_bus[7:0]; upper address bits ignored (0x0150 maps to 0x50, wrap-around).
REQ-022 Write with memory_select=0: no ram_we/rom_en, full cycle timing kept, ready and bus_err pulse together.
REQ-023 Program read (memory_select=0) with captured PSEN high: no rom_en, read buffer = 0xFF, ready and bus_err pulse.
REQ-024 Strobe dropped before ready: transaction still completes; HOLD exits immediately next cycle.
REQ-025 Changes on addr_bus/data_bus after capture SHALL NOT affect the transaction in progress.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, counter=0, read buffer=0x00, ready=bus_err=rom_en=ram_en=ram_we=0, rom_addr=0x0000, ram_addr=ram_wdata=0x00, data_bus high-Z.
REQ-027 Reset mid-transaction SHALL abort it with no pending write or ready pulse after release.

Structure
REQ-028 Shared package mcu51_bus_pkg SHALL hold the state enum, wait-counter width constant (4), and ERR_READ_DATA=8'hFF.
REQ-029 Sub-module mem_wait_counter (load, decrement, zero flag) SHALL implement REQ-016/017.

Verification
REQ-030 Program read, PSEN=0, addr 0x0123, ROM_WAIT=1, rom_rdata=0xC3 -> rom_en one cycle with rom_addr 0x0123, ready 3 cycles after capture, data_bus=0xC3 in HOLD.
REQ-031 Data write addr 0x0150, data 0x50, RAM_WAIT=0 -> ram_we one cycle, ram_addr 0x50, ram_wdata 0x50, ready 2 cycles after capture, bus_err 0.
REQ-032 Write with memory_select=0 -> no ram_we/rom_en, ready and bus_err pulse together.
REQ-033 read_en and write_en both high 5 cycles -> stays IDLE, no enables, no ready; data_bus high-Z.
REQ-034 ROM_WAIT=15 read; reset asserted during WAIT -> all outputs at reset values, no ready after release; next read completes normally.
REQ-035 Back-to-back reads with read_en held high -> exactly one ready; second ready only after read_en low then high.
